cardinal_router_buffered: RTL and testbench

Parametrised five-port mesh router: PE, UP, DOWN, LEFT, RIGHT. It is the buffered successor of the single-register cardinal router.

- Each input has a DEPTH-entry FIFO.
- Each output has a round-robin arbiter and a one-flit output register.
- Routing is XY, using signed hop nibbles carried in the flit; the hop field is adjusted on every forward.
- It sits between a PE and its four mesh neighbours, one instance per tile.

---
 rtl/router_pkg.sv | 65 ++++++
 rtl/router_fifo.sv | 71 +++++++
 rtl/cardinal_router_buffered.sv | 157 +++++++++++++++
 tb/tb_cardinal_router_buffered.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the buffered cardinal router: port indices,
// hop-field representation and the XY routing helpers.
package router_pkg;

  localparam int N_PORTS = 5;
  localparam int P_PE    = 0;
  localparam int P_UP    = 1;
  localparam int P_DOWN  = 2;
  localparam int P_LEFT  = 3;
  localparam int P_RIGHT = 4;

  // Hop fields are sign-extended to this width before routing, so HOP_W
  // must not exceed it.
  localparam int HOP_MAX_W = 16;

  typedef logic [2:0] port_idx_t;

  typedef struct packed {
    logic signed [HOP_MAX_W-1:0] x;
    logic signed [HOP_MAX_W-1:0] y;
  } hops_t;

  localparam logic signed [HOP_MAX_W-1:0] HOP_ZERO = HOP_MAX_W'(0);
  localparam logic signed [HOP_MAX_W-1:0] HOP_ONE  = HOP_MAX_W'(1);

  // XY routing: finish the X leg first, then Y, then deliver locally.
  function automatic port_idx_t route_sel(input hops_t h);
    port_idx_t sel;
    if (h.x > HOP_ZERO) begin
      sel = port_idx_t'(P_RIGHT);
    end else if (h.x < HOP_ZERO) begin
      sel = port_idx_t'(P_LEFT);
    end else if (h.y > HOP_ZERO) begin
      sel = port_idx_t'(P_DOWN);
    end else if (h.y < HOP_ZERO) begin
      sel = port_idx_t'(P_UP);
    end else begin
      sel = port_idx_t'(P_PE);
    end
    return sel;
  endfunction

  // Move the hop field being consumed one step toward zero. Stepping toward
  // zero can never overflow, so even the most negative value is safe.
  function automatic hops_t hop_adjust(input hops_t h);
    hops_t r;
    r = h;
    if (h.x > HOP_ZERO) begin
      r.x = h.x - HOP_ONE;
    end else if (h.x < HOP_ZERO) begin
      r.x = h.x + HOP_ONE;
    end else if (h.y > HOP_ZERO) begin
      r.y = h.y - HOP_ONE;
    end else if (h.y < HOP_ZERO) begin
      r.y = h.y + HOP_ONE;
    end
    return r;
  endfunction

  // Cyclic successor over the five port indices.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(N_PORTS - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input flit FIFO with occupancy counter; empties on asynchronous reset.
module router_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pushEn;
  logic              popEn;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign pushEn = push && !full;
  assign popEn  = pop && !empty;
  assign dout   = mem[rdPtr_q];

  // Pointer and occupancy next-state; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (pushEn && !popEn) begin
      count_d = count_q + CNT_W'(1);
    end else if (popEn && !pushEn) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset discards all stored flits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtr_q] <= din;
    end
  end

endmodule

// File: rtl/cardinal_router_buffered.sv
// Five-port buffered mesh router: input FIFOs, XY routing on FIFO heads,
// round-robin arbitration and a one-flit register per output.
module cardinal_router_buffered
  import router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HOP_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        in_si,
  output logic [N_PORTS-1:0]        in_ri,
  input  logic [N_PORTS*DATA_W-1:0] in_di,
  output logic [N_PORTS-1:0]        out_so,
  input  logic [N_PORTS-1:0]        out_ro,
  output logic [N_PORTS*DATA_W-1:0] out_do
);

  localparam int X_MSB = DATA_W - 9;
  localparam int Y_MSB = DATA_W - 9 - HOP_W;

  logic [N_PORTS-1:0] fifoPush;
  logic [N_PORTS-1:0] fifoPop;
  logic [N_PORTS-1:0] fifoFull;
  logic [N_PORTS-1:0] fifoEmpty;
  logic [DATA_W-1:0]  headData [N_PORTS];
  logic [DATA_W-1:0]  headNext [N_PORTS];
  hops_t              headHops [N_PORTS];
  hops_t              adjHops  [N_PORTS];
  port_idx_t          headSel  [N_PORTS];
  logic [N_PORTS-1:0] outReq   [N_PORTS];
  logic [N_PORTS-1:0] outFree;
  logic [N_PORTS-1:0] grantValid;
  port_idx_t          grantIdx [N_PORTS];
  logic [N_PORTS-1:0] outValid_q, outValid_d;
  logic [DATA_W-1:0]  outData_q [N_PORTS];
  logic [DATA_W-1:0]  outData_d [N_PORTS];
  port_idx_t          rrPtr_q   [N_PORTS];
  port_idx_t          rrPtr_d   [N_PORTS];

  // Ready reflects occupancy only, so a full FIFO refuses a push even when
  // it is popped on the same edge.
  assign in_ri    = ~fifoFull & {N_PORTS{~reset}};
  assign fifoPush = in_si & in_ri;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_fifo
    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifoPush[k]),
      .pop   (fifoPop[k]),
      .din   (in_di[k*DATA_W +: DATA_W]),
      .dout  (headData[k]),
      .full  (fifoFull[k]),
      .empty (fifoEmpty[k])
    );
  end

  // Decode each FIFO head's hop fields, pick its output and prepare the
  // flit as it will leave, with the consumed hop stepped toward zero.
  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      headHops[k].x = HOP_MAX_W'($signed(headData[k][X_MSB -: HOP_W]));
      headHops[k].y = HOP_MAX_W'($signed(headData[k][Y_MSB -: HOP_W]));
      headSel[k]    = route_sel(headHops[k]);
      adjHops[k]    = hop_adjust(headHops[k]);
      headNext[k]   = headData[k];
      headNext[k][X_MSB -: HOP_W] = HOP_W'(adjHops[k].x);
      headNext[k][Y_MSB -: HOP_W] = HOP_W'(adjHops[k].y);
    end
  end

  // Request matrix: outReq[j][k] means non-empty head k wants output j.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      for (int k = 0; k < N_PORTS; k++) begin
        outReq[j][k] = !fifoEmpty[k] && (headSel[k] == port_idx_t'(j));
      end
    end
  end

  // Round-robin arbiters: a free output grants the first requester found
  // scanning cyclically from its pointer.
  always_comb begin
    port_idx_t scanIdx;
    scanIdx = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      outFree[j]    = !outValid_q[j] || out_ro[j];
      grantValid[j] = 1'b0;
      grantIdx[j]   = rrPtr_q[j];
      scanIdx       = rrPtr_q[j];
      for (int i = 0; i < N_PORTS; i++) begin
        if (outFree[j] && !grantValid[j] && outReq[j][scanIdx]) begin
          grantValid[j] = 1'b1;
          grantIdx[j]   = scanIdx;
        end
        scanIdx = next_port(scanIdx);
      end
    end
  end

  // A head requests exactly one output, so each FIFO is popped by at most
  // one grant per cycle.
  always_comb begin
    fifoPop = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (grantValid[j] && (grantIdx[j] == port_idx_t'(k))) begin
          fifoPop[k] = 1'b1;
        end
      end
    end
  end

  // Output register next-state: load on grant, drop on consumption,
  // otherwise hold flit and data stable under backpressure.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      outValid_d[j] = outValid_q[j] && !out_ro[j];
      outData_d[j]  = outData_q[j];
      rrPtr_d[j]    = rrPtr_q[j];
      if (grantValid[j]) begin
        outValid_d[j] = 1'b1;
        outData_d[j]  = headNext[grantIdx[j]];
        rrPtr_d[j]    = next_port(grantIdx[j]);
      end
    end
  end

  // Output registers and arbitration pointers; reset drops in-flight flits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid_q <= '0;
      for (int j = 0; j < N_PORTS; j++) begin
        outData_q[j] <= '0;
        rrPtr_q[j]   <= '0;
      end
    end else begin
      outValid_q <= outValid_d;
      for (int j = 0; j < N_PORTS; j++) begin
        outData_q[j] <= outData_d[j];
        rrPtr_q[j]   <= rrPtr_d[j];
      end
    end
  end

  assign out_so = outValid_q;

  for (genvar j = 0; j < N_PORTS; j++) begin : g_out
    assign out_do[j*DATA_W +: DATA_W] = outData_q[j];
  end

endmodule

// File: tb/tb_cardinal_router_buffered.sv
// Self-checking bench for cardinal_router_buffered: directed scenarios plus
// randomized traffic compared cycle by cycle against a queue-based model.
module tb_cardinal_router_buffered;

  localparam int DW = 64;
  localparam int HW = 4;
  localparam int DP = 4;
  localparam int NP = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   in_si;
  logic [NP-1:0]   in_ri;
  logic [NP*DW-1:0] in_di;
  logic [NP-1:0]   out_so;
  logic [NP-1:0]   out_ro;
  logic [NP*DW-1:0] out_do;

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;

  // Reference model state: one queue per input, plus each output's held
  // flit and its round-robin pointer.
  logic [DW-1:0] mq [NP][$];
  logic          mValid [NP];
  logic [DW-1:0] mData [NP];
  int            mRr [NP];

  always #5 clk = ~clk;

  cardinal_router_buffered #(
    .DATA_W (DW),
    .HOP_W  (HW),
    .DEPTH  (DP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_si  (in_si),
    .in_ri  (in_ri),
    .in_di  (in_di),
    .out_so (out_so),
    .out_ro (out_ro),
    .out_do (out_do)
  );

  function automatic int hopX(input logic [DW-1:0] f);
    logic signed [HW-1:0] v;
    v = f[DW-9 -: HW];
    return int'(v);
  endfunction

  function automatic int hopY(input logic [DW-1:0] f);
    logic signed [HW-1:0] v;
    v = f[DW-9-HW -: HW];
    return int'(v);
  endfunction

  function automatic logic [DW-1:0] makeFlit(input int x, input int y, input logic [31:0] tag,
                                             input logic [7:0] hi);
    logic [DW-1:0] f;
    f = {hi, 8'h00, 16'hBEEF, tag};
    f[DW-9 -: HW]    = HW'(x);
    f[DW-9-HW -: HW] = HW'(y);
    return f;
  endfunction

  function automatic int modelRoute(input logic [DW-1:0] f);
    int x, y;
    x = hopX(f);
    y = hopY(f);
    if (x > 0) return 4;
    if (x < 0) return 3;
    if (y > 0) return 2;
    if (y < 0) return 1;
    return 0;
  endfunction

  function automatic logic [DW-1:0] modelAdjust(input logic [DW-1:0] f);
    logic [DW-1:0] r;
    int x, y;
    x = hopX(f);
    y = hopY(f);
    r = f;
    if (x > 0)      r[DW-9 -: HW]    = HW'(x - 1);
    else if (x < 0) r[DW-9 -: HW]    = HW'(x + 1);
    else if (y > 0) r[DW-9-HW -: HW] = HW'(y - 1);
    else if (y < 0) r[DW-9-HW -: HW] = HW'(y + 1);
    return r;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < NP; k++) begin
      mq[k].delete();
      mValid[k] = 1'b0;
      mData[k]  = '0;
      mRr[k]    = 0;
    end
  endfunction

  // One rising edge of the model, using inputs as they stand at the edge.
  function automatic void modelEdge();
    bit [NP-1:0] rdy;
    int g [NP];
    if (reset) begin
      modelReset();
      return;
    end
    for (int k = 0; k < NP; k++) rdy[k] = (mq[k].size() < DP);
    for (int j = 0; j < NP; j++) begin
      g[j] = -1;
      if (!mValid[j] || out_ro[j]) begin
        for (int i = 0; i < NP; i++) begin
          int k;
          k = (mRr[j] + i) % NP;
          if (g[j] < 0 && mq[k].size() > 0 && modelRoute(mq[k][0]) == j) g[j] = k;
        end
      end
    end
    for (int j = 0; j < NP; j++) begin
      if (g[j] >= 0) begin
        mValid[j] = 1'b1;
        mData[j]  = modelAdjust(mq[g[j]][0]);
        mRr[j]    = (g[j] + 1) % NP;
      end else if (mValid[j] && out_ro[j]) begin
        mValid[j] = 1'b0;
      end
    end
    for (int j = 0; j < NP; j++) begin
      if (g[j] >= 0) void'(mq[g[j]].pop_front());
    end
    for (int k = 0; k < NP; k++) begin
      if (in_si[k] && rdy[k]) mq[k].push_back(in_di[k*DW +: DW]);
    end
  endfunction

  // Expected visible outputs; data only matters where a flit is held.
  function automatic void modelExpect(output logic [NP-1:0] so, output logic [NP-1:0] ri,
                                      output logic [NP*DW-1:0] dv, output logic [NP*DW-1:0] mask);
    for (int j = 0; j < NP; j++) begin
      so[j] = mValid[j];
      ri[j] = !reset && (mq[j].size() < DP);
      dv[j*DW +: DW]   = mValid[j] ? mData[j] : '0;
      mask[j*DW +: DW] = mValid[j] ? '1 : '0;
    end
  endfunction

  task automatic advance();
    @(posedge clk);
    modelEdge();
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_so !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_so: got %b want 00000", out_so);
    end
    checks++;
    if (in_ri !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_ri: got %b want 00000", in_ri);
    end
    checks++;
    if (out_do !== '0) begin
      errors++;
      $display("[TB] FAIL reset_do: got %h want 0", out_do);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ri !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL reset_release_ri: got %b want 11111", in_ri);
    end
  endtask

  task automatic test_single_hop();
    logic [DW-1:0] f, want;
    f    = makeFlit(2, 1, 32'hA0000001, 8'hC3);
    want = makeFlit(1, 1, 32'hA0000001, 8'hC3);
    in_di[0*DW +: DW] = f;
    in_si = 5'b00001;
    checks++;
    if (in_ri[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_hop_ready: got %b want 1", in_ri[0]);
    end
    advance();
    in_si = 5'b00000;
    checks++;
    if (out_so !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL single_hop_early: got %b want 00000", out_so);
    end
    advance();
    checks++;
    if (out_so !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL single_hop_so: got %b want 10000", out_so);
    end
    checks++;
    if (out_do[4*DW +: DW] !== want) begin
      errors++;
      $display("[TB] FAIL single_hop_data: got %h want %h", out_do[4*DW +: DW], want);
    end
    advance();
    checks++;
    if (out_so !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL single_hop_after: got %b want 00000", out_so);
    end
  endtask

  task automatic test_routes();
    logic [DW-1:0] fUp, fDown, fLeft;
    fUp   = makeFlit(0, 2, 32'hB0000001, 8'h21);
    fDown = makeFlit(0, -1, 32'hB0000002, 8'h22);
    fLeft = makeFlit(0, 0, 32'hB0000003, 8'h23);
    in_di[1*DW +: DW] = fUp;
    in_di[2*DW +: DW] = fDown;
    in_di[3*DW +: DW] = fLeft;
    in_si = 5'b01110;
    advance();
    in_si = 5'b00000;
    advance();
    checks++;
    if (out_so !== 5'b00111) begin
      errors++;
      $display("[TB] FAIL routes_so: got %b want 00111", out_so);
    end
    checks++;
    if (out_do[2*DW +: DW] !== makeFlit(0, 1, 32'hB0000001, 8'h21)) begin
      errors++;
      $display("[TB] FAIL routes_down: got %h want %h", out_do[2*DW +: DW], makeFlit(0, 1, 32'hB0000001, 8'h21));
    end
    checks++;
    if (out_do[1*DW +: DW] !== makeFlit(0, 0, 32'hB0000002, 8'h22)) begin
      errors++;
      $display("[TB] FAIL routes_up: got %h want %h", out_do[1*DW +: DW], makeFlit(0, 0, 32'hB0000002, 8'h22));
    end
    checks++;
    if (out_do[0*DW +: DW] !== fLeft) begin
      errors++;
      $display("[TB] FAIL routes_pe: got %h want %h", out_do[0*DW +: DW], fLeft);
    end
    advance();
  endtask

  task automatic test_contention();
    logic [NP-1:0] eSo, eRi;
    logic [NP*DW-1:0] eDo, eMask;
    reset = 1'b1;
    modelReset();
    #1;
    reset = 1'b0;
    #1;
    in_di[0*DW +: DW] = makeFlit(1, 0, 32'hC0000001, 8'h31);
    in_di[3*DW +: DW] = makeFlit(2, 0, 32'hC0000002, 8'h32);
    in_si = 5'b01001;
    advance();
    in_si = 5'b00000;
    advance();
    checks++;
    if (out_so[4] !== 1'b1 || out_do[4*DW +: DW] !== makeFlit(0, 0, 32'hC0000001, 8'h31)) begin
      errors++;
      $display("[TB] FAIL contention_first: got so=%b do=%h want so=1 do=%h", out_so[4],
               out_do[4*DW +: DW], makeFlit(0, 0, 32'hC0000001, 8'h31));
    end
    advance();
    checks++;
    if (out_so[4] !== 1'b1 || out_do[4*DW +: DW] !== makeFlit(1, 0, 32'hC0000002, 8'h32)) begin
      errors++;
      $display("[TB] FAIL contention_second: got so=%b do=%h want so=1 do=%h", out_so[4],
               out_do[4*DW +: DW], makeFlit(1, 0, 32'hC0000002, 8'h32));
    end
    // Repeat the same contention with the pointer wherever the rules left it.
    in_di[0*DW +: DW] = makeFlit(1, 0, 32'hC0000003, 8'h33);
    in_di[3*DW +: DW] = makeFlit(2, 0, 32'hC0000004, 8'h34);
    in_si = 5'b01001;
    for (int c = 0; c < 5; c++) begin
      advance();
      in_si = 5'b00000;
      modelExpect(eSo, eRi, eDo, eMask);
      checks++;
      if ({out_so, in_ri, out_do & eMask} !== {eSo, eRi, eDo}) begin
        errors++;
        $display("[TB] FAIL contention_repeat cycle %0d: got so=%b ri=%b do=%h want so=%b ri=%b do=%h",
                 cycleNo, out_so, in_ri, out_do & eMask, eSo, eRi, eDo);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NP-1:0] eSo, eRi;
    logic [NP*DW-1:0] eDo, eMask;
    logic [DW-1:0] rx [6];
    int rxCycle [6];
    int sent, got;
    bit acc;
    sent = 0;
    got  = 0;
    out_ro = 5'b01111;
    for (int c = 0; c < 10; c++) begin
      in_si[0] = (sent < 6);
      in_di[0*DW +: DW] = makeFlit(1, 0, 32'hD0000000 + sent, 8'h11);
      acc = in_si[0] && in_ri[0];
      advance();
      if (acc) sent++;
      modelExpect(eSo, eRi, eDo, eMask);
      checks++;
      if ({out_so, in_ri, out_do & eMask} !== {eSo, eRi, eDo}) begin
        errors++;
        $display("[TB] FAIL backpressure_fill cycle %0d: got so=%b ri=%b do=%h want so=%b ri=%b do=%h",
                 cycleNo, out_so, in_ri, out_do & eMask, eSo, eRi, eDo);
      end
    end
    checks++;
    if (sent != 5 || in_ri[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_accepts: got %0d accepted ri=%b want 5 accepted ri=0", sent, in_ri[0]);
    end
    checks++;
    if (out_so[4] !== 1'b1 || out_do[4*DW +: DW] !== makeFlit(0, 0, 32'hD0000000, 8'h11)) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: got so=%b do=%h want so=1 do=%h", out_so[4],
               out_do[4*DW +: DW], makeFlit(0, 0, 32'hD0000000, 8'h11));
    end
    out_ro = 5'b11111;
    for (int c = 0; c < 30 && got < 6; c++) begin
      in_si[0] = (sent < 6);
      in_di[0*DW +: DW] = makeFlit(1, 0, 32'hD0000000 + sent, 8'h11);
      if (out_so[4] && out_ro[4]) begin
        rx[got]      = out_do[4*DW +: DW];
        rxCycle[got] = c;
        got++;
      end
      acc = in_si[0] && in_ri[0];
      advance();
      if (acc) sent++;
      modelExpect(eSo, eRi, eDo, eMask);
      checks++;
      if ({out_so, in_ri, out_do & eMask} !== {eSo, eRi, eDo}) begin
        errors++;
        $display("[TB] FAIL backpressure_drain cycle %0d: got so=%b ri=%b do=%h want so=%b ri=%b do=%h",
                 cycleNo, out_so, in_ri, out_do & eMask, eSo, eRi, eDo);
      end
    end
    in_si = 5'b00000;
    checks++;
    if (got != 6) begin
      errors++;
      $display("[TB] FAIL backpressure_count: got %0d flits want 6", got);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx[i] !== makeFlit(0, 0, 32'hD0000000 + i, 8'h11)) begin
          errors++;
          $display("[TB] FAIL backpressure_order[%0d]: got %h want %h", i, rx[i],
                   makeFlit(0, 0, 32'hD0000000 + i, 8'h11));
        end
      end
      checks++;
      if (rxCycle[5] - rxCycle[0] != 5) begin
        errors++;
        $display("[TB] FAIL backpressure_rate: got span %0d cycles want 5", rxCycle[5] - rxCycle[0]);
      end
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [NP-1:0] eSo, eRi;
    logic [NP*DW-1:0] eDo, eMask;
    int cnt [NP];
    int mn, mx;
    for (int k = 0; k < NP; k++) cnt[k] = 0;
    out_ro = 5'b11111;
    in_si  = 5'b11111;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NP; k++)
        in_di[k*DW +: DW] = makeFlit(0, 0, 32'hF0000000 | k, 8'($urandom));
      if (c >= 10 && out_so[0] && out_ro[0]) cnt[int'(out_do[2:0]) % NP]++;
      advance();
      modelExpect(eSo, eRi, eDo, eMask);
      checks++;
      if ({out_so, in_ri, out_do & eMask} !== {eSo, eRi, eDo}) begin
        errors++;
        $display("[TB] FAIL fairness cycle %0d: got so=%b ri=%b do=%h want so=%b ri=%b do=%h",
                 cycleNo, out_so, in_ri, out_do & eMask, eSo, eRi, eDo);
      end
    end
    in_si = 5'b00000;
    mn = cnt[0];
    mx = cnt[0];
    for (int k = 1; k < NP; k++) begin
      if (cnt[k] < mn) mn = cnt[k];
      if (cnt[k] > mx) mx = cnt[k];
    end
    checks++;
    if (mn == 0 || mx - mn > 1) begin
      errors++;
      $display("[TB] FAIL fairness_share: got counts %0d %0d %0d %0d %0d want equal within 1",
               cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
    end
    repeat (25) advance();
  endtask

  task automatic test_random();
    logic [NP-1:0] eSo, eRi;
    logic [NP*DW-1:0] eDo, eMask;
    for (int c = 0; c < 440; c++) begin
      if (c < 400) begin
        in_si = NP'($urandom);
        for (int k = 0; k < NP; k++)
          in_di[k*DW +: DW] = makeFlit(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                                       $urandom, 8'($urandom));
        for (int j = 0; j < NP; j++) out_ro[j] = ($urandom_range(3) != 0);
      end else begin
        in_si  = 5'b00000;
        out_ro = 5'b11111;
      end
      advance();
      modelExpect(eSo, eRi, eDo, eMask);
      checks++;
      if ({out_so, in_ri, out_do & eMask} !== {eSo, eRi, eDo}) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got so=%b ri=%b do=%h want so=%b ri=%b do=%h",
                 cycleNo, out_so, in_ri, out_do & eMask, eSo, eRi, eDo);
      end
    end
  endtask

  task automatic test_reset_midflight();
    out_ro = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      in_di[0*DW +: DW] = makeFlit(1, 0, 32'hE0000000 + i, 8'h44);
      in_si = 5'b00001;
      advance();
    end
    in_si = 5'b00000;
    checks++;
    if (out_so[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midflight_loaded: got %b want 1", out_so[4]);
    end
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checks++;
    if (out_so !== 5'b00000 || in_ri !== 5'b00000 || out_do !== '0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: got so=%b ri=%b do=%h want so=00000 ri=00000 do=0",
               out_so, in_ri, out_do);
    end
    out_ro = 5'b11111;
    reset  = 1'b0;
    #1;
    checks++;
    if (in_ri !== 5'b11111) begin
      errors++;
      $display("[TB] FAIL midflight_release_ri: got %b want 11111", in_ri);
    end
    for (int c = 0; c < 6; c++) begin
      advance();
      checks++;
      if (out_so !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL midflight_stale cycle %0d: got %b want 00000", cycleNo, out_so);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    in_si  = '0;
    in_di  = '0;
    out_ro = '1;
    modelReset();
    test_reset();
    test_single_hop();
    test_routes();
    test_contention();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
